// File: rtl/id_scoreboard.sv
// Decode-stage register hazard scoreboard: tracks remaining producer latency per
// register, raises a stall for dependent sources and counts hazard-stall cycles.
module id_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int LAT_W      = 3,
  parameter int MAX_LAT    = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  reg1_read_i,
  input  logic [REG_ADDR_W-1:0] reg1_addr_i,
  input  logic                  reg2_read_i,
  input  logic [REG_ADDR_W-1:0] reg2_addr_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_wreg_i,
  input  logic [REG_ADDR_W-1:0] issue_wd_i,
  input  logic [LAT_W-1:0]      issue_lat_i,
  output logic                  reg1_busy_o,
  output logic                  reg2_busy_o,
  output logic                  stallreq_o,
  output logic [REG_ADDR_W:0]   busy_count_o,
  output logic [PERF_W-1:0]     stall_cycles_o
);

  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

  // Register 0 has no storage; cnt_view presents it as permanently idle.
  logic [LAT_W-1:0] cnt      [1:NUM_REGS-1];
  logic [LAT_W-1:0] cnt_dec  [1:NUM_REGS-1];
  logic [LAT_W-1:0] cnt_next [1:NUM_REGS-1];
  logic [LAT_W-1:0] cnt_view [NUM_REGS];
  logic [LAT_W-1:0] lat_clamped;
  logic             issue_fire;
  logic [REG_ADDR_W:0] busy_total;

  always_comb begin
    cnt_view[0] = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      cnt_view[r] = cnt[r];
    end
  end

  always_comb begin
    reg1_busy_o = reg1_read_i && (reg1_addr_i != '0) && (int'(reg1_addr_i) < NUM_REGS)
                  && (cnt_view[reg1_addr_i] != '0);
    reg2_busy_o = reg2_read_i && (reg2_addr_i != '0) && (int'(reg2_addr_i) < NUM_REGS)
                  && (cnt_view[reg2_addr_i] != '0);
    stallreq_o  = reg1_busy_o | reg2_busy_o;
  end

  always_comb begin
    lat_clamped = (issue_lat_i > MAX_L) ? MAX_L : issue_lat_i;
    issue_fire  = issue_valid_i && issue_wreg_i && (issue_wd_i != '0)
                  && !stallreq_o && !stall_i && !flush_i;
  end

  // The max against the decremented count keeps a longer outstanding wait intact.
  always_comb begin
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      cnt_dec[r]  = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
      cnt_next[r] = cnt_dec[r];
      if (issue_fire && (issue_wd_i == REG_ADDR_W'(r)) && (lat_clamped > cnt_dec[r])) begin
        cnt_next[r] = lat_clamped;
      end
    end
  end

  always_comb begin
    busy_total = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      busy_total = busy_total + {{REG_ADDR_W{1'b0}}, (cnt[r] != '0)};
    end
    busy_count_o = busy_total;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      if (stallreq_o && (stall_cycles_o != '1)) begin
        stall_cycles_o <= stall_cycles_o + PERF_W'(1);
      end
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (flush_i) begin
          cnt[r] <= '0;
        end else if (!stall_i) begin
          cnt[r] <= cnt_next[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios plus randomized traffic checked
// against a model that tracks, per register, the epoch at which it becomes free.
module tb_id_scoreboard;

  logic       clk = 1'b0;
  logic       rst, flush, stall;
  logic       reg1_read, reg2_read;
  logic [4:0] reg1_addr, reg2_addr;
  logic       issue_valid, issue_wreg;
  logic [4:0] issue_wd;
  logic [2:0] issue_lat;
  logic       reg1_busy, reg2_busy, stallreq;
  logic [5:0] busy_count;
  logic [31:0] stall_cycles;
  logic       p3_reg1_busy, p3_reg2_busy, p3_stallreq;
  logic [5:0] p3_busy_count;
  logic [2:0] p3_stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a register is free once the advance epoch reaches ready_at[r].
  longint epoch;
  longint ready_at [32];
  longint perf;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
    .reg1_read_i(reg1_read), .reg1_addr_i(reg1_addr),
    .reg2_read_i(reg2_read), .reg2_addr_i(reg2_addr),
    .issue_valid_i(issue_valid), .issue_wreg_i(issue_wreg),
    .issue_wd_i(issue_wd), .issue_lat_i(issue_lat),
    .reg1_busy_o(reg1_busy), .reg2_busy_o(reg2_busy), .stallreq_o(stallreq),
    .busy_count_o(busy_count), .stall_cycles_o(stall_cycles)
  );

  id_scoreboard #(.PERF_W(3)) dut_p3 (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
    .reg1_read_i(reg1_read), .reg1_addr_i(reg1_addr),
    .reg2_read_i(reg2_read), .reg2_addr_i(reg2_addr),
    .issue_valid_i(issue_valid), .issue_wreg_i(issue_wreg),
    .issue_wd_i(issue_wd), .issue_lat_i(issue_lat),
    .reg1_busy_o(p3_reg1_busy), .reg2_busy_o(p3_reg2_busy), .stallreq_o(p3_stallreq),
    .busy_count_o(p3_busy_count), .stall_cycles_o(p3_stall_cycles)
  );

  function automatic bit m_busy(input logic rd, input logic [4:0] addr);
    return rd && (addr != 0) && (ready_at[addr] > epoch);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 1; r < 32; r++) if (ready_at[r] > epoch) n++;
    return n;
  endfunction

  task automatic idle();
    rst = 0; flush = 0; stall = 0;
    reg1_read = 0; reg1_addr = 0; reg2_read = 0; reg2_addr = 0;
    issue_valid = 0; issue_wreg = 0; issue_wd = 0; issue_lat = 0;
  endtask

  task automatic tick();
    bit stl, fire;
    longint l;
    stl = m_busy(reg1_read, reg1_addr) || m_busy(reg2_read, reg2_addr);
    @(posedge clk);
    if (rst) begin
      epoch = 0; perf = 0;
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
    end else begin
      if (stl) perf++;
      if (flush) begin
        for (int r = 0; r < 32; r++) ready_at[r] = epoch;
      end else if (!stall) begin
        fire = issue_valid && issue_wreg && (issue_wd != 0) && !stl;
        epoch++;
        if (fire) begin
          l = (issue_lat > 4) ? 4 : longint'(issue_lat);
          if (epoch + l > ready_at[issue_wd]) ready_at[issue_wd] = epoch + l;
        end
      end
    end
    #1;
  endtask

  task automatic issue(input int wd, input int lat);
    issue_valid = 1; issue_wreg = 1; issue_wd = 5'(wd); issue_lat = 3'(lat);
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    reg1_read = 1; reg1_addr = 5; #1;
    n_checks++; if (busy_count !== 6'd0) $display("FAIL reset_busy_count: got %0d want 0", busy_count); else n_pass++;
    n_checks++; if (stallreq !== 1'b0) $display("FAIL reset_stallreq: got %0b want 0", stallreq); else n_pass++;
    n_checks++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); else n_pass++;
    n_checks++; if (reg1_busy !== 1'b0) $display("FAIL reset_reg1_busy: got %0b want 0", reg1_busy); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    idle(); issue(3, 1); tick();
    idle(); reg1_read = 1; reg1_addr = 3; #1;
    n_checks++; if (stallreq !== 1'b1) $display("FAIL load_use_stall: got %0b want 1", stallreq); else n_pass++;
    tick();
    n_checks++; if (stallreq !== 1'b0) $display("FAIL load_use_release: got %0b want 0", stallreq); else n_pass++;
    n_checks++; if (stall_cycles !== 32'd1) $display("FAIL load_use_perf: got %0d want 1", stall_cycles); else n_pass++;
    tick();
  endtask

  task automatic test_clamp();
    idle(); issue(8, 7); tick();
    idle(); reg2_read = 1; reg2_addr = 8;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (stallreq !== 1'b1) $display("FAIL clamp_stall[%0d]: got %0b want 1", i, stallreq); else n_pass++;
      n_checks++; if (busy_count !== 6'd1) $display("FAIL clamp_count[%0d]: got %0d want 1", i, busy_count); else n_pass++;
      tick();
    end
    n_checks++; if (stallreq !== 1'b0) $display("FAIL clamp_release: got %0b want 0", stallreq); else n_pass++;
    n_checks++; if (busy_count !== 6'd0) $display("FAIL clamp_drained: got %0d want 0", busy_count); else n_pass++;
  endtask

  task automatic test_waw();
    idle(); issue(9, 4); tick();
    issue(9, 1); tick();
    idle(); reg1_read = 1; reg1_addr = 9;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (stallreq !== 1'b1) $display("FAIL waw_stall[%0d]: got %0b want 1", i, stallreq); else n_pass++;
      tick();
    end
    n_checks++; if (stallreq !== 1'b0) $display("FAIL waw_release: got %0b want 0", stallreq); else n_pass++;
    idle(); issue(0, 4); tick(); idle(); #1;
    n_checks++; if (busy_count !== 6'd0) $display("FAIL waw_r0_count: got %0d want 0", busy_count); else n_pass++;
  endtask

  task automatic test_freeze_flush();
    idle(); issue(2, 3); tick();
    idle(); stall = 1; reg1_read = 1; reg1_addr = 2;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (stallreq !== 1'b1) $display("FAIL freeze_stall[%0d]: got %0b want 1", i, stallreq); else n_pass++;
      n_checks++; if (busy_count !== 6'd1) $display("FAIL freeze_count[%0d]: got %0d want 1", i, busy_count); else n_pass++;
      tick();
    end
    stall = 0; flush = 1; tick(); flush = 0; #1;
    n_checks++; if (busy_count !== 6'd0) $display("FAIL flush_count: got %0d want 0", busy_count); else n_pass++;
    n_checks++; if (stallreq !== 1'b0) $display("FAIL flush_stall: got %0b want 0", stallreq); else n_pass++;
    tick();
  endtask

  task automatic test_self_dep();
    idle(); reg1_read = 1; reg1_addr = 4; issue(4, 2); #1;
    n_checks++; if (stallreq !== 1'b0) $display("FAIL self_dep_stall: got %0b want 0", stallreq); else n_pass++;
    tick();
    issue_valid = 0; #1;
    n_checks++; if (reg1_busy !== 1'b1) $display("FAIL self_dep_accepted: got %0b want 1", reg1_busy); else n_pass++;
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_perf_sat();
    idle(); rst = 1; tick(); rst = 0;
    issue(5, 4); tick();
    idle(); reg1_read = 1; reg1_addr = 5; stall = 1;
    for (int i = 0; i < 10; i++) tick();
    #1;
    n_checks++; if (p3_stall_cycles !== 3'd7) $display("FAIL perf_sat_p3: got %0d want 7", p3_stall_cycles); else n_pass++;
    n_checks++; if (stall_cycles !== 32'd10) $display("FAIL perf_sat_wide: got %0d want 10", stall_cycles); else n_pass++;
    idle(); flush = 1; tick(); idle();
  endtask

  task automatic test_random();
    bit e1, e2;
    longint p3;
    idle(); rst = 1; tick();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(199) == 0);
      flush       = ($urandom_range(39) == 0);
      stall       = ($urandom_range(7) == 0);
      reg1_read   = 1'($urandom);
      reg1_addr   = 5'($urandom_range(7));
      reg2_read   = 1'($urandom);
      reg2_addr   = 5'($urandom_range(7));
      issue_valid = 1'($urandom);
      issue_wreg  = ($urandom_range(3) != 0);
      issue_wd    = 5'($urandom_range(7));
      issue_lat   = 3'($urandom_range(7));
      #1;
      e1 = m_busy(reg1_read, reg1_addr);
      e2 = m_busy(reg2_read, reg2_addr);
      p3 = (perf > 7) ? 7 : perf;
      n_checks++; if (reg1_busy !== e1) $display("FAIL rnd_reg1_busy[%0d]: got %0b want %0b", i, reg1_busy, e1); else n_pass++;
      n_checks++; if (reg2_busy !== e2) $display("FAIL rnd_reg2_busy[%0d]: got %0b want %0b", i, reg2_busy, e2); else n_pass++;
      n_checks++; if (stallreq !== (e1 | e2)) $display("FAIL rnd_stallreq[%0d]: got %0b want %0b", i, stallreq, e1 | e2); else n_pass++;
      n_checks++; if (int'(busy_count) !== m_count()) $display("FAIL rnd_busy_count[%0d]: got %0d want %0d", i, busy_count, m_count()); else n_pass++;
      n_checks++; if (longint'(stall_cycles) !== perf) $display("FAIL rnd_stall_cycles[%0d]: got %0d want %0d", i, stall_cycles, perf); else n_pass++;
      n_checks++; if (longint'(p3_stall_cycles) !== p3) $display("FAIL rnd_p3_cycles[%0d]: got %0d want %0d", i, p3_stall_cycles, p3); else n_pass++;
      tick();
    end
  endtask

  initial begin
    epoch = 0; perf = 0;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_clamp();
    test_waw();
    test_freeze_flush();
    test_self_dep();
    test_perf_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the decode stage. Generalises the single load-use stall check into per-register remaining-latency tracking, so multi-cycle producers (loads, mul/div, cp0 reads) stall dependent consumers without hard-wired opcode checks.
- Sits beside decode. Decode presents its source operands and its own write-back target. The scoreboard returns stallreq to ctrl.
- Also counts hazard-stall cycles for performance analysis.

Parameters:
REG_ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W max)
LAT_W, 3, width of per-register latency counter
MAX_LAT, 4, largest accepted producer latency; must be <= 2**LAT_W-1
PERF_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush (exception/eret); clears all tracking
stall_i  in  1  pipeline frozen by ctrl from a stage other than decode; freezes scoreboard
reg1_read_i  in  1  decode reads source 1
reg1_addr_i  in  REG_ADDR_W  source 1 address
reg2_read_i  in  1  decode reads source 2
reg2_addr_i  in  REG_ADDR_W  source 2 address
issue_valid_i  in  1  decode holds a valid instruction this cycle
issue_wreg_i  in  1  instruction writes a register
issue_wd_i  in  REG_ADDR_W  destination register
issue_lat_i  in  LAT_W  cycles until the result is forwardable; 0 = forwardable next cycle (plain ALU)
reg1_busy_o  out  1  source 1 blocked
reg2_busy_o  out  1  source 2 blocked
stallreq_o  out  1  hazard stall request to ctrl
busy_count_o  out  REG_ADDR_W+1  number of registers currently pending
stall_cycles_o  out  PERF_W  saturating count of cycles with stallreq_o high

Behaviour:
- State: cnt[r], LAT_W bits, for r in 0..NUM_REGS-1, plus the perf counter. Register 0 is hard-wired: cnt[0] is never written, always 0.
- Reset (rst=1 at clk edge):
  - all cnt cleared to 0 and stall_cycles_o cleared to 0.
  - All outputs then read 0, since they are combinational on cleared state.
  - Reset takes priority over flush_i, stall_i and issue.
- Busy signals, combinational:
  - regN_busy_o = regN_read_i & (regN_addr_i != 0) & (cnt[regN_addr_i] != 0).
  - stallreq_o = reg1_busy_o | reg2_busy_o.
  - These use the current registered cnt only. An instruction never blocks on its own destination (e.g. lw $1,0($1)).
- Issue acceptance: issue_fire = issue_valid_i & issue_wreg_i & (issue_wd_i != 0) & ~stallreq_o & ~stall_i & ~flush_i.
- Per-edge update, priority order:
  - rst: as above.
  - flush_i: all cnt <= 0. stall_cycles_o still counts if stallreq_o was high.
  - stall_i: cnt held. Perf counter still updates.
  - Otherwise:
    - every nonzero cnt[r] decrements by 1.
    - On issue_fire, the target is overwritten: cnt[issue_wd_i] <= max(cnt[issue_wd_i]-1 saturated at 0, L), where L = min(issue_lat_i, MAX_LAT).
    - A later producer never shortens an outstanding longer wait (WAW safety).
- Latency meaning:
  - Producer issued with L at edge t leaves cnt=L after t.
  - A consumer is stalled in the L cycles following t and may proceed in cycle t+L+1.
  - L=0 leaves no trace.
- busy_count_o: popcount of (cnt[r] != 0), r = 1..NUM_REGS-1. Combinational.
- stall_cycles_o: increments by 1 on each edge where stallreq_o=1 and not rst. Saturates at all-ones; does not wrap.
- Simultaneous events:
  - An issue and a decrement on the same register resolve by the max rule.
  - Issue while stallreq_o=1 is dropped; decode re-presents it the next cycle.
  - Query addresses equal to issue_wd_i in the same cycle see the pre-update value.

Test Plan:
- Reset then idle: rst high 2 cycles -> busy_count_o=0, stallreq_o=0, stall_cycles_o=0; reg1_read_i=1, addr=5 -> reg1_busy_o=0.
- Load-use: issue wd=3, lat=1; next cycle reg1_addr=3 read -> stallreq_o=1 for exactly 1 cycle, then 0; stall_cycles_o=1.
- Long producer with clamp: issue wd=8, lat=7 (MAX_LAT=4) -> cnt=4, dependent reg2_addr=8 stalled 4 cycles; busy_count_o=1 throughout, then 0.
- WAW/no-shorten: issue wd=9 lat=4, next cycle issue wd=9 lat=1 -> cnt[9]=3 after second edge; consumer stalls 3 more cycles. Issue wd=0 lat=4 -> busy_count_o unchanged.
- Freeze and flush: issue wd=2 lat=3, assert stall_i 5 cycles -> cnt held at 3, busy persists. Then flush_i 1 cycle -> busy_count_o=0, consumer of $2 unstalled next cycle.
- Self-dependence and perf saturation:
  - reg1_addr=4, issue wd=4 lat=2 in the same cycle -> no stall, issue accepted.
  - With PERF_W=3, hold a hazard 10 cycles -> stall_cycles_o sticks at 7.
